// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXE    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_IEXE   = 4'd12,
    S_IWB    = 4'd13
  } state_e;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type funct codes
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Register-file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write data select
  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MDR = 2'b01;
  localparam logic [1:0] WDSEL_PC  = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// Maps an R-type funct field to the ALU operation and flags unsupported codes.
// Latency: purely combinational.
// Backpressure: none.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  // funct -> ALU operation lookup
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADDU: alu_op = ALU_ADD;
      FN_SUBU: alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 2..5 cycles per instruction; outputs decoded from state (Zero->PCWr in BRANCH only).
// Backpressure: none; advances one state per clock.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q, state_d;
  // ALU op and extension mode captured in DECODE so later states do not
  // depend on the op/funct inputs combinationally.
  logic [2:0] alu_op_q, alu_op_d;
  logic       ext_sign_q, ext_sign_d;

  logic [2:0] fn_alu_op;
  logic       fn_legal;

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (fn_alu_op),
    .legal  (fn_legal)
  );

  // State and decoded-operation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      alu_op_q   <= ALU_ADD;
      ext_sign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      ext_sign_q <= ext_sign_d;
    end
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    ext_sign_d = ext_sign_q;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    DMWr       = 1'b0;
    RegDst     = REGDST_RT;
    WDSel      = WDSEL_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    EXTOp      = 1'b0;
    ALUOp      = ALU_ADD;
    PCSrc      = PCSRC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        ALUSrcB = SRCB_FOUR;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        // ALUOut <= PC+4 + (sext(imm)<<2), the branch target
        ALUSrcB    = SRCB_BOFF;
        EXTOp      = 1'b1;
        alu_op_d   = fn_alu_op;
        ext_sign_d = 1'b1;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (fn_legal) begin
              state_d = S_EXE;
            end else begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: begin
            alu_op_d = ALU_ADD;
            state_d  = S_IEXE;
          end
          OP_ORI: begin
            alu_op_d   = ALU_OR;
            ext_sign_d = 1'b0;
            state_d    = S_IEXE;
          end
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_EXT;
        EXTOp   = 1'b1;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: state_d = S_MEMWB;

      S_MEMWB: begin
        RFWr       = 1'b1;
        RegDst     = REGDST_RT;
        WDSel      = WDSEL_MDR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        DMWr       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_EXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = alu_op_q;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        RFWr       = 1'b1;
        RegDst     = REGDST_RD;
        WDSel      = WDSEL_ALU;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALU_SUB;
        PCSrc      = PCSRC_ALUOUT;
        PCWr       = Zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        PCWr       = 1'b1;
        PCSrc      = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        // PC still holds PC+4 here, so RF captures the link value on the
        // same edge that loads the jump target.
        PCWr       = 1'b1;
        PCSrc      = PCSRC_JUMP;
        RFWr       = 1'b1;
        RegDst     = REGDST_RA;
        WDSel      = WDSEL_PC;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_EXT;
        EXTOp   = ext_sign_q;
        ALUOp   = alu_op_q;
        state_d = S_IWB;
      end

      S_IWB: begin
        RFWr       = 1'b1;
        RegDst     = REGDST_RT;
        WDSel      = WDSEL_ALU;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule
